multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/ctrl_pkg.sv | 31 +++
 rtl/instr_decode.sv | 27 ++
 rtl/multicycle_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle controller: instruction
// classes, FSM states and the fixed ALU opcodes the controller issues.
// Build option: MULTICYCLE_CTRL_MEM_TIMEOUT_EN (used in multicycle_ctrl).
package ctrl_pkg;

    typedef enum logic [1:0] {
        T_R = 2'b00,
        T_M = 2'b01,
        T_B = 2'b10,
        T_S = 2'b11
    } instr_type_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [2:0] ALU_LOAD  = 3'b011;
    localparam logic [2:0] ALU_STORE = 3'b100;
    localparam logic [2:0] ALU_CMP   = 3'b101;
    localparam logic [2:0] ALU_LI    = 3'b110;

    // funct codes that make an M-type instruction legal
    localparam int unsigned FUNCT_LOAD  = 0;
    localparam int unsigned FUNCT_STORE = 1;

endpackage

// File: rtl/instr_decode.sv
// Combinational field decode of the latched instruction register.
// Build option: none (MULTICYCLE_CTRL_MEM_TIMEOUT_EN only affects the top).
module instr_decode
    import ctrl_pkg::*;
#(
    parameter int INSTR_W  = 9,
    parameter int ALU_OP_W = 3
) (
    input  logic [INSTR_W-1:0]  i_ir,
    output instr_type_t         o_type,
    output logic [ALU_OP_W-1:0] o_funct,
    output logic                o_legal,
    output logic                o_is_halt
);

    // Only M-type carries funct values that can be illegal; an S-type with
    // every bit below the type field set is the halt instruction.
    always_comb begin
        o_type    = instr_type_t'(i_ir[INSTR_W-1 -: 2]);
        o_funct   = i_ir[INSTR_W-3 -: ALU_OP_W];
        o_legal   = (o_type != T_M)
                 || (o_funct == ALU_OP_W'(FUNCT_LOAD))
                 || (o_funct == ALU_OP_W'(FUNCT_STORE));
        o_is_halt = (o_type == T_S) && (&i_ir[INSTR_W-3:0]);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle instruction controller: accepts one instruction at a time,
// walks it through DECODE/EXEC/MEM/WB and drives the datapath strobes.
// Build option: define MULTICYCLE_CTRL_MEM_TIMEOUT_EN to bound MEM waits by
// TIMEOUT cycles (fault + HALT on expiry); otherwise MEM waits forever.
//
// state  | meaning
// IDLE   | ready for a new instruction, latches it into ir when valid
// DECODE | one cycle to classify ir; illegal M funct faults here
// EXEC   | ALU step for R/B/S; branch retires here
// MEM    | load/store strobe held until mem_ack; store retires on ack
// WB     | register write-back and retire
// HALT   | done asserted, everything else quiet until reset
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int INSTR_W  = 9,
    parameter int ALU_OP_W = 3,
    parameter int TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [INSTR_W-1:0]  instr,
    input  logic                zero_flag,
    input  logic                mem_ack,
    output logic                jump,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_write,
    output logic                pc_en,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                done,
    output logic                fault
);

    if (INSTR_W < ALU_OP_W + 3) begin : g_bad_width
        $error("INSTR_W must be at least ALU_OP_W+3");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    state_t               r_state;
    logic [INSTR_W-1:0]   r_ir;
    logic                 r_fault;

    instr_type_t          w_type;
    logic [ALU_OP_W-1:0]  w_funct;
    logic                 w_legal;
    logic                 w_is_halt;
    logic                 w_is_store;

`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    logic [WAIT_W-1:0]    r_wait;
`endif

    instr_decode #(
        .INSTR_W  (INSTR_W),
        .ALU_OP_W (ALU_OP_W)
    ) u_decode (
        .i_ir      (r_ir),
        .o_type    (w_type),
        .o_funct   (w_funct),
        .o_legal   (w_legal),
        .o_is_halt (w_is_halt)
    );

    assign w_is_store = (w_funct == ALU_OP_W'(FUNCT_STORE));

    // State, instruction latch, sticky fault and optional MEM wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ir    <= '0;
            r_fault <= 1'b0;
`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
            r_wait  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_ir    <= instr;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
                    r_wait <= '0;
`endif
                    if (!w_legal) begin
                        r_fault <= 1'b1;
                        r_state <= S_HALT;
                    end else if (w_type == T_M) begin
                        r_state <= S_MEM;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_type == T_B) begin
                        r_state <= S_IDLE;
                    end else if (w_is_halt) begin
                        r_state <= S_HALT;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        r_state <= w_is_store ? S_IDLE : S_WB;
`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
                    end else if (r_wait == WAIT_LAST) begin
                        r_fault <= 1'b1;
                        r_state <= S_HALT;
                    end else begin
                        r_wait <= r_wait + 1'b1;
`endif
                    end
                end
                S_WB: begin
                    r_state <= S_IDLE;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Datapath strobes decoded from state and ir; the branch jump and the
    // store-retire pc_en follow the inputs sampled in that same cycle, and a
    // mem_ack arriving together with reset must not retire the store.
    always_comb begin
        instr_ready = 1'b0;
        jump        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        pc_en       = 1'b0;
        alu_op      = '0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                instr_ready = 1'b1;
            end
            S_EXEC: begin
                case (w_type)
                    T_R: alu_op = w_funct;
                    T_B: begin
                        alu_op = ALU_OP_W'(ALU_CMP);
                        jump   = zero_flag;
                        pc_en  = 1'b1;
                    end
                    T_S: begin
                        if (!w_is_halt) begin
                            alu_op = ALU_OP_W'(ALU_LI);
                        end
                    end
                    default: alu_op = '0;
                endcase
            end
            S_MEM: begin
                if (w_is_store) begin
                    alu_op    = ALU_OP_W'(ALU_STORE);
                    mem_write = 1'b1;
                    pc_en     = mem_ack && !reset;
                end else begin
                    alu_op    = ALU_OP_W'(ALU_LOAD);
                    mem_read  = 1'b1;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_en     = 1'b1;
            end
            S_HALT: begin
                done = 1'b1;
            end
            default: begin
                instr_ready = 1'b0;
            end
        endcase
    end

    assign fault = r_fault;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    localparam int INSTR_W  = 9;
    localparam int ALU_OP_W = 3;
    localparam int TIMEOUT  = 15;
`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                instr_valid;
    logic                instr_ready;
    logic [INSTR_W-1:0]  instr;
    logic                zero_flag;
    logic                mem_ack;
    logic                jump;
    logic                mem_read;
    logic                mem_write;
    logic                reg_write;
    logic                pc_en;
    logic [ALU_OP_W-1:0] alu_op;
    logic                done;
    logic                fault;

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .INSTR_W  (INSTR_W),
        .ALU_OP_W (ALU_OP_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .zero_flag   (zero_flag),
        .mem_ack     (mem_ack),
        .jump        (jump),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .pc_en       (pc_en),
        .alu_op      (alu_op),
        .done        (done),
        .fault       (fault)
    );

    // ready jump mem_read mem_write reg_write pc_en alu_op done fault
    typedef struct packed {
        logic       ready;
        logic       jump;
        logic       mr;
        logic       mw;
        logic       rw;
        logic       pc;
        logic [2:0] alu;
        logic       done;
        logic       fault;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    logic m_fault = 1'b0;
    int   retired = 0;
    int   pc_seen = 0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [INSTR_W-1:0] rinstr();
        return INSTR_W'($urandom);
    endfunction

    // Drive one cycle of inputs, compare all outputs at the falling edge.
    task automatic cyc(input string name, input logic v, input logic [INSTR_W-1:0] ins,
                       input logic zf, input logic ack, input logic rst, input exp_t e);
        exp_t a;
        instr_valid = v;
        instr       = ins;
        zero_flag   = zf;
        mem_ack     = ack;
        reset       = rst;
        @(negedge clk);
        a = '{instr_ready, jump, mem_read, mem_write, reg_write, pc_en, alu_op, done, fault};
        if (pc_en === 1'b1) pc_seen++;
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s t=%0t actual=%b required=%b (rdy,jmp,mr,mw,rw,pc,alu,done,fault)",
                     name, $time, a, e);
        end
        @(posedge clk);
        #1;
    endtask

    // Cycle with arbitrary don't-care inputs (no reset, random mem_ack).
    task automatic gcyc(input string name, input exp_t e);
        cyc(name, rb(), rinstr(), rb(), rb(), 1'b0, e);
    endtask

    task automatic halt_and_reset(input int n);
        exp_t e;
        e = '0;
        e.done  = 1'b1;
        e.fault = m_fault;
        for (int i = 0; i < n; i++) gcyc("halt", e);
        cyc("halt_rst", rb(), rinstr(), rb(), rb(), 1'b1, e);
        m_fault = 1'b0;
    endtask

    // Reference model: derive the per-cycle output sequence of one
    // instruction straight from its type/funct and the memory wait count.
    task automatic run_instr(input logic [INSTR_W-1:0] ins, input int nwait, input int rst_at);
        exp_t       e;
        logic [1:0] typ;
        logic [2:0] f;
        logic       zf;
        logic       ack;
        logic       rst;
        bit         timed_out;
        typ = ins[8:7];
        f   = ins[6:4];
        timed_out = 1'b0;
        e = '0; e.ready = 1'b1;
        cyc("accept", 1'b1, ins, rb(), rb(), 1'b0, e);
        e = '0;
        gcyc("decode", e);
        case (typ)
            2'b00: begin
                e.alu = f;
                gcyc("exec_r", e);
                e = '0; e.rw = 1'b1; e.pc = 1'b1;
                gcyc("wb_r", e);
                retired++;
            end
            2'b10: begin
                zf = rb();
                e.alu = 3'b101; e.jump = zf; e.pc = 1'b1;
                cyc("exec_b", rb(), rinstr(), zf, rb(), 1'b0, e);
                retired++;
            end
            2'b11: begin
                if (ins[6:0] == 7'h7f) begin
                    gcyc("exec_s_halt", e);
                    halt_and_reset(3);
                end else begin
                    e.alu = 3'b110;
                    gcyc("exec_s", e);
                    e = '0; e.rw = 1'b1; e.pc = 1'b1;
                    gcyc("wb_s", e);
                    retired++;
                end
            end
            default: begin
                if (f > 3'd1) begin
                    m_fault = 1'b1;
                    halt_and_reset(3);
                end else begin
                    for (int k = 0; k <= nwait; k++) begin
                        if (TO_EN && k == TIMEOUT) begin
                            timed_out = 1'b1;
                            break;
                        end
                        rst = (k == rst_at);
                        ack = (k == nwait) || rst;
                        e = '0;
                        if (f == 3'd0) begin
                            e.alu = 3'b011; e.mr = 1'b1;
                        end else begin
                            e.alu = 3'b100; e.mw = 1'b1; e.pc = ack && !rst;
                        end
                        cyc("mem", rb(), rinstr(), rb(), ack, rst, e);
                        if (rst) return;
                    end
                    if (timed_out) begin
                        m_fault = 1'b1;
                        halt_and_reset(3);
                    end else if (f == 3'd0) begin
                        e = '0; e.rw = 1'b1; e.pc = 1'b1;
                        gcyc("wb_ld", e);
                        retired++;
                    end else begin
                        retired++;
                    end
                end
            end
        endcase
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        logic [INSTR_W-1:0] ins;
        int   t;
        int   sel;
        logic [2:0] f;
        instr_valid = 1'b0;
        instr       = '0;
        zero_flag   = 1'b0;
        mem_ack     = 1'b1;
        reset       = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Literal pins: reset state and an R-type (alu_op 010) walk-through
        cyc("reset_idle", 1'b0, '0, 1'b0, 1'b0, 1'b0, exp_t'(11'b100_0000_0000));
        cyc("r_accept", 1'b1, 9'b00_010_0000, 1'b0, 1'b0, 1'b0, exp_t'(11'b100_0000_0000));
        cyc("r_decode", 1'b1, 9'b01_111_1111, 1'b1, 1'b1, 1'b0, exp_t'(11'b000_0000_0000));
        cyc("r_exec", 1'b1, 9'b11_111_1111, 1'b0, 1'b0, 1'b0, exp_t'(11'b000_0000_1000));
        cyc("r_wb", 1'b0, '0, 1'b0, 1'b0, 1'b0, exp_t'(11'b000_0110_0000));
        cyc("r_idle", 1'b0, '0, 1'b0, 1'b0, 1'b0, exp_t'(11'b100_0000_0000));

        // Literal pins: branch taken and not taken
        cyc("b1_accept", 1'b1, 9'b10_000_0000, 1'b0, 1'b0, 1'b0, exp_t'(11'b100_0000_0000));
        cyc("b1_decode", 1'b0, '0, 1'b0, 1'b0, 1'b0, exp_t'(11'b000_0000_0000));
        cyc("b1_exec", 1'b0, '0, 1'b1, 1'b0, 1'b0, exp_t'(11'b010_0011_0100));
        cyc("b0_accept", 1'b1, 9'b10_000_0000, 1'b1, 1'b0, 1'b0, exp_t'(11'b100_0000_0000));
        cyc("b0_decode", 1'b0, '0, 1'b1, 1'b0, 1'b0, exp_t'(11'b000_0000_0000));
        cyc("b0_exec", 1'b0, '0, 1'b0, 1'b0, 1'b0, exp_t'(11'b000_0011_0100));

        // Literal pins: load with two wait cycles
        cyc("ld_accept", 1'b1, 9'b01_000_0000, 1'b0, 1'b0, 1'b0, exp_t'(11'b100_0000_0000));
        cyc("ld_decode", 1'b0, '0, 1'b0, 1'b0, 1'b0, exp_t'(11'b000_0000_0000));
        cyc("ld_mem0", 1'b0, '0, 1'b0, 1'b0, 1'b0, exp_t'(11'b001_0000_1100));
        cyc("ld_mem1", 1'b1, '1, 1'b0, 1'b0, 1'b0, exp_t'(11'b001_0000_1100));
        cyc("ld_mem2", 1'b0, '0, 1'b0, 1'b1, 1'b0, exp_t'(11'b001_0000_1100));
        cyc("ld_wb", 1'b0, '0, 1'b0, 1'b0, 1'b0, exp_t'(11'b000_0110_0000));

        // Literal pins: illegal M funct 111 faults and halts until reset
        cyc("ill_accept", 1'b1, 9'b01_111_0000, 1'b0, 1'b0, 1'b0, exp_t'(11'b100_0000_0000));
        cyc("ill_decode", 1'b0, '0, 1'b0, 1'b0, 1'b0, exp_t'(11'b000_0000_0000));
        cyc("ill_halt0", 1'b1, '0, 1'b0, 1'b1, 1'b0, exp_t'(11'b000_0000_0011));
        cyc("ill_halt1", 1'b1, '0, 1'b0, 1'b0, 1'b0, exp_t'(11'b000_0000_0011));
        cyc("ill_rst", 1'b0, '0, 1'b0, 1'b0, 1'b1, exp_t'(11'b000_0000_0011));
        cyc("ill_after", 1'b0, '0, 1'b0, 1'b0, 1'b0, exp_t'(11'b100_0000_0000));

        // Model-driven directed cases: store reset on 2nd MEM cycle, S halt,
        // and a load whose ack never comes within 100 cycles
        run_instr(9'b01_001_0000, 5, 1);
        e = '0; e.ready = 1'b1;
        cyc("post_rst_idle", 1'b0, '0, 1'b0, 1'b1, 1'b0, e);
        run_instr(9'b11_111_1111, 0, -1);
        run_instr(9'b11_010_0110, 0, -1);
        run_instr(9'b01_000_0101, 100, -1);
        run_instr(9'b01_001_0011, 0, -1);

        // Randomized instruction stream with idle gaps
        retired = 0;
        pc_seen = 0;
        for (int n = 0; n < 60; n++) begin
            t = $urandom_range(0, 3);
            f = 3'($urandom);
            ins = rinstr();
            if (t == 1) begin
                sel = $urandom_range(0, 9);
                f = (sel <= 3) ? 3'd0 : (sel <= 7) ? 3'd1 : 3'($urandom_range(2, 7));
            end
            ins[8:7] = 2'(t);
            ins[6:4] = f;
            if (t == 3 && $urandom_range(0, 5) == 0) ins[6:0] = 7'h7f;
            run_instr(ins, $urandom_range(0, 5),
                      ($urandom_range(0, 7) == 0) ? $urandom_range(0, 5) : -1);
            repeat ($urandom_range(0, 2)) begin
                e = '0; e.ready = 1'b1;
                cyc("idle_gap", 1'b0, rinstr(), rb(), rb(), 1'b0, e);
            end
        end
        checks++;
        if (pc_seen != retired) begin
            errors++;
            $display("FAIL pc_en_count actual=%0d required=%0d", pc_seen, retired);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
